// File: rtl/seqgen_defs.sv
// ============================================================================
// seqgen_defs : shared state encoding and width defaults for seqgen_ctrl
// Revision    : 1.0
// ============================================================================
`default_nettype none

package seqgen_defs;

  localparam int DATA_W_DEF = 4;
  localparam int LEN_W_DEF  = 4;
  localparam int DIV_W_DEF  = 8;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_EMIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/seq_prescaler.sv
// ============================================================================
// seq_prescaler : loadable down-counter with hold and zero flag
// Revision      : 1.0
// ============================================================================
`default_nettype none

module seq_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [DIV_W-1:0] cnt;

  // Load has priority; a dec request at zero leaves the counter parked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/seqgen_ctrl.sv
// ============================================================================
// seqgen_ctrl : run controller for the odd-sequence generator (clear, pace,
//               capture a fixed number of terms, signal completion)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module seqgen_ctrl
  import seqgen_defs::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DATA_W-1:0] gen_out,
  output logic              gen_clr,
  output logic              gen_en,
  output logic              term_valid,
  output logic [DATA_W-1:0] term_data,
  output logic [LEN_W-1:0]  term_cnt,
  output logic              busy,
  output logic              done
);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [DIV_W-1:0] div_q;
  logic [LEN_W-1:0] cnt_inc;
  logic             pre_load;
  logic             pre_dec;
  logic             pre_zero;

  assign cnt_inc  = term_cnt + 1'b1;
  // Reloading on the final EMIT is harmless: the prescaler is unused in DONE.
  assign pre_load = (state == ST_CLEAR) || (state == ST_EMIT);
  assign pre_dec  = (state == ST_WAIT) && !pause;

  seq_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .load     (pre_load),
    .load_val (div_q),
    .dec      (pre_dec),
    .zero     (pre_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      div_q    <= '0;
      term_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            len_q    <= cfg_len;
            div_q    <= cfg_div;
            term_cnt <= '0;
            state    <= (cfg_len == '0) ? ST_DONE : ST_CLEAR;
          end
        end
        ST_CLEAR: state <= abort ? ST_IDLE : ST_WAIT;
        ST_WAIT: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (!pause && pre_zero) begin
            state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          // The term is delivered even when abort arrives in this cycle.
          term_cnt <= cnt_inc;
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            state <= (cnt_inc == len_q) ? ST_DONE : ST_WAIT;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign gen_clr    = (state == ST_CLEAR);
  assign gen_en     = (state == ST_EMIT);
  assign term_valid = (state == ST_EMIT);
  assign term_data  = (state == ST_EMIT) ? gen_out : '0;
  assign done       = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_seqgen_ctrl.sv
// ============================================================================
// tb_seqgen_ctrl : directed bench for seqgen_ctrl with a 13,11,..,3 generator
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_seqgen_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, pause;
  logic [3:0] cfg_len;
  logic [7:0] cfg_div;
  logic [3:0] gen_out;
  logic       gen_clr, gen_en, term_valid, busy, done;
  logic [3:0] term_data, term_cnt;

  int checks = 0;
  int errors = 0;

  seqgen_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .pause      (pause),
    .cfg_len    (cfg_len),
    .cfg_div    (cfg_div),
    .gen_out    (gen_out),
    .gen_clr    (gen_clr),
    .gen_en     (gen_en),
    .term_valid (term_valid),
    .term_data  (term_data),
    .term_cnt   (term_cnt),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Generator model: clear -> 13, each enable steps down by 2, 3 wraps to 13.
  logic [3:0] gen_val = 4'd0;
  always @(posedge clk) begin
    if (gen_clr)     gen_val <= 4'd13;
    else if (gen_en) gen_val <= (gen_val == 4'd3) ? 4'd13 : gen_val - 4'd2;
  end
  assign gen_out = gen_val;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({gen_clr, gen_en, term_valid, busy, done, term_data, term_cnt});
  endfunction

  typedef struct {
    logic       s;
    logic       a;
    logic [3:0] len;
    logic [7:0] div;
    logic [4:0] flags;   // clr, en, valid, busy, done
    logic [3:0] dat;
    logic [3:0] cnt;
  } vec_t;

  function automatic vec_t mk(logic s, logic a, logic [3:0] l, logic [7:0] d,
                              logic [4:0] f, logic [3:0] dat, logic [3:0] cnt);
    vec_t v;
    v.s = s; v.a = a; v.len = l; v.div = d; v.flags = f; v.dat = dat; v.cnt = cnt;
    return v;
  endfunction

  // Results captured by run_seq
  int         tv_cyc[$];
  logic [3:0] tv_dat[$];
  int         n_done, n_clr, n_en, end_cyc;

  task automatic run_seq(input logic [3:0] len, input logic [7:0] div,
                         input int pause_at, input int pause_n,
                         input int abort_at, input int extra_start_at);
    bit ended = 0;
    tv_cyc.delete(); tv_dat.delete();
    n_done = 0; n_clr = 0; n_en = 0; end_cyc = -1;
    for (int k = 0; k < 300; k++) begin
      start   = (k == 0) || (k == extra_start_at);
      abort   = (k == abort_at);
      pause   = (k >= pause_at) && (k < pause_at + pause_n);
      cfg_len = (k == 0) ? len : 4'd15;
      cfg_div = (k == 0) ? div : 8'd0;
      @(negedge clk);
      if (k > 0) begin
        if (term_valid) begin
          tv_cyc.push_back(k);
          tv_dat.push_back(term_data);
        end
        if (done)    n_done++;
        if (gen_clr) n_clr++;
        if (gen_en)  n_en++;
        if (!busy) begin
          ended   = 1;
          end_cyc = k;
        end
      end
      @(posedge clk); #1;
      if (ended) break;
    end
    start = 0; abort = 0; pause = 0;
    chk("run_terminates", int'(ended), 1);
  endtask

  task automatic chk_terms(input string tag, input int exp_cyc[$], input int first_idx);
    logic [3:0] seq6 [6];
    seq6[0] = 4'd13; seq6[1] = 4'd11; seq6[2] = 4'd9;
    seq6[3] = 4'd7;  seq6[4] = 4'd5;  seq6[5] = 4'd3;
    chk({tag, "_nterms"}, tv_cyc.size(), exp_cyc.size());
    chk({tag, "_nen"}, n_en, exp_cyc.size());
    for (int i = 0; i < exp_cyc.size() && i < tv_cyc.size(); i++) begin
      chk($sformatf("%s_cyc%0d", tag, i), tv_cyc[i], exp_cyc[i]);
      chk($sformatf("%s_dat%0d", tag, i), int'(tv_dat[i]), int'(seq6[(first_idx + i) % 6]));
    end
  endtask

  vec_t vt [16];

  initial begin
    vt[0]  = mk(1, 0, 3, 0, 5'b00000, 0,  0);
    vt[1]  = mk(0, 0, 3, 0, 5'b10010, 0,  0);
    vt[2]  = mk(0, 0, 3, 0, 5'b00010, 0,  0);
    vt[3]  = mk(0, 0, 3, 0, 5'b01110, 13, 0);
    vt[4]  = mk(0, 0, 3, 0, 5'b00010, 0,  1);
    vt[5]  = mk(0, 0, 3, 0, 5'b01110, 11, 1);
    vt[6]  = mk(0, 0, 3, 0, 5'b00010, 0,  2);
    vt[7]  = mk(0, 0, 3, 0, 5'b01110, 9,  2);
    vt[8]  = mk(0, 0, 3, 0, 5'b00011, 0,  3);
    vt[9]  = mk(0, 0, 3, 0, 5'b00000, 0,  3);
    vt[10] = mk(1, 0, 0, 0, 5'b00000, 0,  3);
    vt[11] = mk(0, 0, 0, 0, 5'b00011, 0,  0);
    vt[12] = mk(0, 0, 0, 0, 5'b00000, 0,  0);
    vt[13] = mk(1, 1, 5, 0, 5'b00000, 0,  0);
    vt[14] = mk(0, 0, 5, 0, 5'b00000, 0,  0);
    vt[15] = mk(0, 0, 5, 0, 5'b00000, 0,  0);

    rst = 1; start = 0; abort = 0; pause = 0; cfg_len = 0; cfg_div = 0;
    #2;
    chk("reset_outputs", outs(), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Cycle-exact table: len=3/div=0 run, len=0 run, start+abort in IDLE
    foreach (vt[i]) begin
      start = vt[i].s; abort = vt[i].a; cfg_len = vt[i].len; cfg_div = vt[i].div;
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs(), int'({vt[i].flags, vt[i].dat, vt[i].cnt}));
      @(posedge clk); #1;
    end
    start = 0; abort = 0;

    // len=8, div=3, stray start at cycle 10
    run_seq(4'd8, 8'd3, -1, 0, -1, 10);
    chk_terms("A", '{6, 11, 16, 21, 26, 31, 36, 41}, 0);
    chk("A_done", n_done, 1);
    chk("A_clr", n_clr, 1);
    chk("A_cnt", int'(term_cnt), 8);
    chk("A_end", end_cyc, 43);

    // len=4, div=3, pause held 6 cycles in the second WAIT
    run_seq(4'd4, 8'd3, 7, 6, -1, -1);
    chk_terms("B", '{6, 17, 22, 27}, 0);
    chk("B_done", n_done, 1);
    chk("B_cnt", int'(term_cnt), 4);
    chk("B_end", end_cyc, 29);

    // len=5, div=1, abort in WAIT after two terms
    run_seq(4'd5, 8'd1, -1, 0, 8, -1);
    chk_terms("C", '{4, 7}, 0);
    chk("C_done", n_done, 0);
    chk("C_end", end_cyc, 9);
    chk("C_cnt", int'(term_cnt), 2);

    // Restart after abort: generator must be realigned to 13
    run_seq(4'd1, 8'd0, -1, 0, -1, -1);
    chk_terms("D", '{3}, 0);
    chk("D_clr", n_clr, 1);
    chk("D_done", n_done, 1);
    chk("D_cnt", int'(term_cnt), 1);
    chk("D_end", end_cyc, 5);

    // Asynchronous reset while in WAIT with a partial count
    cfg_len = 4'd3; cfg_div = 8'd4; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("R_pre_busy", int'(busy), 1);
    chk("R_pre_cnt", int'(term_cnt), 1);
    #2 rst = 1;
    #1;
    chk("R_outputs", outs(), 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("R_idle", outs(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seqgen_ctrl.md
Name: seqgen_ctrl

Overview:
Run controller for the 4-bit odd-sequence generator datapath (counter, adder, shifter chain). It clears the generator, paces its advance with a programmable prescaler, and captures a fixed number of terms per run. It presents each term with a one-cycle valid strobe and signals completion. It replaces free-running divided-clock stepping with a single-clock, enable-driven run/abort/pause interface.

Parameters:
DATA_W, 4, generator output width
LEN_W, 4, width of term-count config and counter (max run 2^LEN_W-1 terms)
DIV_W, 8, width of prescaler config

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  run request, sampled in IDLE only
abort  input  1  terminate run
pause  input  1  freeze prescaler while high
cfg_len  input  LEN_W  terms to emit this run
cfg_div  input  DIV_W  extra idle cycles between terms
gen_out  input  DATA_W  current generator value
gen_clr  output  1  synchronous clear to generator (returns it to first term)
gen_en  output  1  advance generator one term at next edge
term_valid  output  1  term_data valid this cycle
term_data  output  DATA_W  captured term
term_cnt  output  LEN_W  terms emitted in current/last run
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async): state IDLE, prescaler 0, len_q/div_q 0, term_cnt 0, all outputs 0.
- Outputs are decoded from registered state: gen_clr=CLEAR, gen_en=term_valid=EMIT, done=DONE; term_data=gen_out while EMIT, else 0.
- IDLE: start=1 and abort=0 -> latch cfg_len->len_q, cfg_div->div_q, clear term_cnt. If cfg_len==0 -> DONE, else -> CLEAR. abort=1 wins over start (stay IDLE).
- CLEAR (1 cycle): gen_clr=1; load prescaler with div_q; -> WAIT.
- WAIT: if pause=0 and prescaler==0 -> EMIT; else if pause=0, decrement; pause=1 holds value. Minimum 1 cycle.
- EMIT (1 cycle): term_valid=1, gen_en=1, term_cnt+1. If term_cnt+1==len_q -> DONE; else reload prescaler with div_q, -> WAIT. pause ignored in EMIT.
- DONE (1 cycle): done=1; -> IDLE. term_cnt holds final value until next accepted start.
- Timing: start sampled at edge 0 -> CLEAR cycle 1, WAIT cycle 2, first EMIT cycle 3+div_q. Term period = div_q+2 cycles with pause low.
- abort: any non-IDLE state -> IDLE at next edge. No done pulse. term_cnt keeps its partial value. An EMIT cycle in which abort is sampled still completes (term visible, generator advances).
- start while busy: ignored, not queued. cfg_* changes during a run: ignored.
- term_cnt never wraps: len_q <= 2^LEN_W-1 bounds it.
- rst mid-run: immediate return to reset values. gen_clr is not issued by reset; the next run's CLEAR realigns the generator.

Decomposition:
- Shared package/header seqgen_defs: state encoding (IDLE, CLEAR, WAIT, EMIT, DONE; 3-bit), DATA_W, LEN_W, DIV_W defaults.
- One sub-module: seq_prescaler (loadable down-counter with hold and zero flag, DIV_W wide). FSM, term counter, and capture stay in seqgen_ctrl.

Test Plan:
- Bench drives a generator model: after gen_clr it outputs 13; each gen_en steps 13,11,9,7,5,3 then wraps to 13.
- Reset: assert rst mid-cycle during WAIT -> all outputs 0 immediately, state IDLE, term_cnt 0.
- cfg_len=3, cfg_div=0, start at edge 0 -> gen_clr in cycle 1; term_valid in cycles 3,5,7 with term_data 13,11,9; done in cycle 8; term_cnt=3; busy low from cycle 9.
- cfg_len=8, cfg_div=3 -> eight terms spaced 5 cycles: 13,11,9,7,5,3,13,11; done once; start pulsed at cycle 10 has no effect.
- cfg_len=4, cfg_div=3, pause high for 6 cycles in the second WAIT -> gap between terms 1 and 2 is 11 cycles; other gaps 5; data 13,11,9,7.
- cfg_len=5, abort during WAIT after 2 terms -> busy low next cycle, no done, no further gen_en, term_cnt=2. Restart with cfg_len=1 -> gen_clr, single term 13, done.
- cfg_len=0, start -> DONE in cycle 1, no gen_clr, no term_valid, term_cnt=0. start+abort together in IDLE -> stays IDLE, busy 0.
